// File: rtl/serializer_pkg.sv
// Shared helpers for the multi-lane DDR serializer: counter sizing and the
// mapping from shift-register slot to source bit of the parallel word.
package serializer_pkg;

    function automatic int cnt_w(input int h);
        return (h <= 1) ? 1 : $clog2(h);
    endfunction

    // Slot i of the rising-edge register is the (2i)-th bit on the wire.
    function automatic int re_idx(input int i, input int dat_w, input bit msb_first);
        return msb_first ? (dat_w - 1 - 2 * i) : (2 * i);
    endfunction

    // Slot i of the falling-edge register is the (2i+1)-th bit on the wire.
    function automatic int fe_idx(input int i, input int dat_w, input bit msb_first);
        return msb_first ? (dat_w - 2 - 2 * i) : (2 * i + 1);
    endfunction

endpackage

// File: rtl/serializer_ddr_lane.sv
// One serializer lane: splits a word into rising/falling half-rate streams
// and shifts them out toward bit 0, one pair per clock.
module serializer_ddr_lane
    import serializer_pkg::*;
#(
    parameter int DAT_W     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [DAT_W-1:0] word,
    output logic             ser_re,
    output logic             ser_fe
);

    localparam int H = DAT_W / 2;

    logic [H-1:0] re_word;
    logic [H-1:0] fe_word;
    logic [H-1:0] re_q;
    logic [H-1:0] fe_q;

    for (genvar i = 0; i < H; i++) begin : g_split
        localparam int RI = re_idx(i, DAT_W, MSB_FIRST);
        localparam int FI = fe_idx(i, DAT_W, MSB_FIRST);
        assign re_word[i] = word[RI];
        assign fe_word[i] = word[FI];
    end

    // NOTE: sequential state uses non-blocking assignments only; these shift
    // registers are reset so the wire sits low until the first word arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            re_q <= '0;
            fe_q <= '0;
        end else if (load) begin
            re_q <= re_word;
            fe_q <= fe_word;
        end else begin
            re_q <= re_q >> 1;
            fe_q <= fe_q >> 1;
        end
    end

    assign ser_re = re_q[0];
    assign ser_fe = fe_q[0];

endmodule

// File: rtl/serializer_ddr_mc.sv
// Multi-channel DDR serializer top: shared slot counter, single valid/ready
// handshake, idle-word substitution with underrun flag, NUM_CH lanes.
module serializer_ddr_mc
    import serializer_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DAT_W     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH*DAT_W-1:0] dat_i,
    input  logic                    vld_i,
    output logic                    rdy_o,
    input  logic [NUM_CH*DAT_W-1:0] idle_i,
    output logic [NUM_CH-1:0]       ser_re_o,
    output logic [NUM_CH-1:0]       ser_fe_o,
    output logic                    underrun_o
);

    localparam int H  = DAT_W / 2;
    localparam int CW = cnt_w(H);
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    if ((DAT_W < 2) || ((DAT_W % 2) != 0)) begin : g_bad_dat_w
        $error("serializer_ddr_mc: DAT_W must be even and >= 2");
    end

    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic                    rdy_q;
    logic                    underrun_q;
    logic                    load;
    logic                    take;
    logic [NUM_CH*DAT_W-1:0] word;

    // NOTE: cnt_d gets its default before the wrap override, so no latch forms.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign load = (cnt_q == LAST);
    assign take = vld_i && rdy_q;
    assign word = take ? dat_i : idle_i;

    // rdy is registered off cnt_d so it lines up with the load edge exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rdy_q      <= (cnt_d == LAST);
            underrun_q <= load && !take;
        end
    end

    assign rdy_o      = rdy_q;
    assign underrun_o = underrun_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        serializer_ddr_lane #(
            .DAT_W    (DAT_W),
            .MSB_FIRST(MSB_FIRST)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .load  (load),
            .word  (word[n*DAT_W +: DAT_W]),
            .ser_re(ser_re_o[n]),
            .ser_fe(ser_fe_o[n])
        );
    end

endmodule

// File: tb/tb_serializer_ddr_mc.sv
// Scoreboard bench for serializer_ddr_mc: an LSB-first and an MSB-first
// instance share stimulus; a wire-order reference model predicts every cycle.
module tb_serializer_ddr_mc;

    localparam int NUM_CH = 3;
    localparam int W      = 10;
    localparam int H      = W / 2;
    localparam int WA     = NUM_CH * W;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [WA-1:0]     dat_i = '0;
    logic [WA-1:0]     idle_i = '0;
    logic              vld_i = 1'b0;
    logic              rdy0, rdy1, und0, und1;
    logic [NUM_CH-1:0] re0, fe0, re1, fe1;

    always #5 clk_i = ~clk_i;

    serializer_ddr_mc #(.NUM_CH(NUM_CH), .DAT_W(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy0),
        .idle_i(idle_i), .ser_re_o(re0), .ser_fe_o(fe0), .underrun_o(und0)
    );

    serializer_ddr_mc #(.NUM_CH(NUM_CH), .DAT_W(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy1),
        .idle_i(idle_i), .ser_re_o(re1), .ser_fe_o(fe1), .underrun_o(und1)
    );

    typedef struct {
        logic              rdy;
        logic              und;
        logic [NUM_CH-1:0] re0, fe0, re1, fe1;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 0;
    int         edge_n = 0;
    int         slot = 0;
    bit         have_word = 0;
    logic [W-1:0] cur[NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // k-th bit on the wire for a word, in transmission order.
    function automatic logic wire_bit(input logic [W-1:0] w, input int k, input bit msb);
        return msb ? w[W-1-k] : w[k];
    endfunction

    // Drive inputs for the next edge, predict what that edge produces, wait.
    task automatic step(input logic v, input logic [WA-1:0] d);
        exp_t e;
        vld_i  = v;
        dat_i  = d;
        edge_n++;
        e.und  = 1'b0;
        if (edge_n >= H && (edge_n % H) == 0) begin
            for (int n = 0; n < NUM_CH; n++)
                cur[n] = v ? d[n*W +: W] : idle_i[n*W +: W];
            e.und     = !v;
            slot      = 0;
            have_word = 1;
        end else if (have_word) begin
            slot++;
        end
        e.rdy = ((edge_n + 1) % H) == 0;
        for (int n = 0; n < NUM_CH; n++) begin
            e.re0[n] = have_word ? wire_bit(cur[n], 2*slot, 1'b0)   : 1'b0;
            e.fe0[n] = have_word ? wire_bit(cur[n], 2*slot+1, 1'b0) : 1'b0;
            e.re1[n] = have_word ? wire_bit(cur[n], 2*slot, 1'b1)   : 1'b0;
            e.fe1[n] = have_word ? wire_bit(cur[n], 2*slot+1, 1'b1) : 1'b0;
        end
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic rnd_step();
        step(1'($urandom_range(0, 1)), WA'($urandom));
    endtask

    // Advance until the next edge is a load boundary.
    task automatic sync_boundary();
        while (((edge_n + 1) % H) != 0 || (edge_n + 1) < H) rnd_step();
    endtask

    task automatic release_reset();
        rst_ni    = 1'b1;
        edge_n    = 0;
        slot      = 0;
        have_word = 0;
        mon_en    = 1;
    endtask

    always @(posedge clk_i) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: output seen with no prediction at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdy_lsb", 32'(rdy0), 32'(mon_e.rdy));
                check("rdy_msb", 32'(rdy1), 32'(mon_e.rdy));
                check("und_lsb", 32'(und0), 32'(mon_e.und));
                check("und_msb", 32'(und1), 32'(mon_e.und));
                check("re_lsb", 32'(re0), 32'(mon_e.re0));
                check("fe_lsb", 32'(fe0), 32'(mon_e.fe0));
                check("re_msb", 32'(re1), 32'(mon_e.re1));
                check("fe_msb", 32'(fe1), 32'(mon_e.fe1));
            end
        end
    end

    initial begin
        logic [4:0]    re_l, fe_l, re_m, fe_m;
        logic [WA-1:0] d;

        repeat (3) @(negedge clk_i);
        check("rst_rdy", 32'({rdy0, rdy1}), 32'd0);
        check("rst_und", 32'({und0, und1}), 32'd0);
        check("rst_ser", 32'({re0, fe0, re1, fe1}), 32'd0);

        // Idle-only run: zero idle word, vld low.
        release_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, WA'($urandom));
            check("idle_ser_zero", 32'({re0, fe0, re1, fe1}), 32'd0);
            check("idle_rdy_pos", 32'(rdy0), 32'((i % H) == 4));
        end

        // Single word 0x34E on lane 0, both bit orders.
        idle_i = WA'($urandom);
        re_l = 5'b11010; fe_l = 5'b10011;
        re_m = 5'b11001; fe_m = 5'b01011;
        sync_boundary();
        d = WA'($urandom);
        d[W-1:0] = 10'h34E;
        step(1'b1, d);
        for (int j = 0; j < H; j++) begin
            if (j > 0) rnd_step();
            check("w34e_re_lsb", 32'(re0[0]), 32'(re_l[j]));
            check("w34e_fe_lsb", 32'(fe0[0]), 32'(fe_l[j]));
            check("w34e_re_msb", 32'(re1[0]), 32'(re_m[j]));
            check("w34e_fe_msb", 32'(fe1[0]), 32'(fe_m[j]));
            check("w34e_no_und", 32'(und0), 32'd0);
        end

        // Back-to-back all-ones then all-zeros, vld held high.
        sync_boundary();
        repeat (H) step(1'b1, {NUM_CH{10'h3FF}});
        check("b2b_ones", 32'({re0, fe0}), 32'h3F);
        repeat (H) step(1'b1, {NUM_CH{10'h000}});
        check("b2b_zeros", 32'({re0, fe0}), 32'h00);

        // One missed boundary with idle 0x155 on lane 0.
        idle_i = WA'($urandom);
        idle_i[W-1:0] = 10'h155;
        sync_boundary();
        step(1'b0, WA'($urandom));
        check("underrun_pulse", 32'(und0), 32'd1);
        for (int j = 0; j < H; j++) begin
            if (j > 0) begin
                step(1'b1, WA'($urandom));
                check("underrun_one_cycle", 32'(und0), 32'd0);
            end
            check("idle155_re", 32'(re0[0]), 32'd1);
            check("idle155_fe", 32'(fe0[0]), 32'd0);
        end
        repeat (H) step(1'b1, WA'($urandom));

        // Randomized traffic with occasional underruns.
        idle_i = WA'($urandom);
        repeat (300) step(1'($urandom_range(0, 3) != 0), WA'($urandom));

        // Reset mid-word: outputs must clear without a clock edge.
        sync_boundary();
        step(1'b1, {NUM_CH{10'h3FF}});
        step(1'b1, WA'($urandom));
        check("pre_rst_ones", 32'({re0, fe0}), 32'h3F);
        #2;
        mon_en = 0;
        exp_q.delete();
        rst_ni = 1'b0;
        #1;
        check("async_rst_ser", 32'({re0, fe0, re1, fe1}), 32'd0);
        check("async_rst_rdy_und", 32'({rdy0, rdy1, und0, und1}), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        release_reset();
        for (int i = 1; i <= 6; i++) begin
            rnd_step();
            check("post_rst_rdy", 32'(rdy0), 32'(i == 4));
        end
        repeat (10) rnd_step();

        mon_en = 0;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
